// File: rtl/rx_fcs_pkg.sv
// Shared constants, state encoding and helpers for the receive FCS check stage.
package rx_fcs_pkg;

    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [15:0] MIN_FRAME_LEN = 16'd64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } rx_state_e;

    // One reflected CRC-32 byte step, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/crc32_d32_be.sv
// Combinational CRC-32 update over the first nbytes (1..4) of a word, byte 0 on [31:24].
module crc32_d32_be
    import rx_fcs_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data_in,
    input  logic [2:0]  nbytes,
    output logic [31:0] crc_out
);

    logic [31:0] crc_b1;
    logic [31:0] crc_b2;
    logic [31:0] crc_b3;
    logic [31:0] crc_b4;

    assign crc_b1 = crc32_byte(crc_in, data_in[31:24]);
    assign crc_b2 = crc32_byte(crc_b1, data_in[23:16]);
    assign crc_b3 = crc32_byte(crc_b2, data_in[15:8]);
    assign crc_b4 = crc32_byte(crc_b3, data_in[7:0]);

    always_comb begin
        case (nbytes)
            3'd1:    crc_out = crc_b1;
            3'd2:    crc_out = crc_b2;
            3'd3:    crc_out = crc_b3;
            default: crc_out = crc_b4;
        endcase
    end

endmodule

// File: rtl/rx_fcs_chk.sv
// Receive frame check: CRC-32/length checking, one-beat forwarding and frame statistics.
// Optional build macro RX_FCS_STRIP_EN removes the 4 FCS bytes from the forwarded stream.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | between frames; only a sop word opens a frame
// ST_FRAME | frame open; CRC and length accumulate until eop
module rx_fcs_chk
    import rx_fcs_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        par_en,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [1:0]  in_mod,
    input  logic        clr_cnt,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic [1:0]  out_mod,
    output logic [15:0] out_len,
    output logic        out_fcs_err,
    output logic        out_runt,
    output logic        out_giant,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_fcs_err,
    output logic [31:0] cnt_runt,
    output logic [31:0] cnt_giant,
    output logic [31:0] cnt_abort
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    rx_state_e   state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;

    logic        beat_vld, word_take, orphan, abandon, frame_end;
    logic [2:0]  nbytes;
    logic [31:0] crc_base, crc_next;
    logic [15:0] len_base, len_new;
    logic [16:0] len_sum;
    logic        fcs_bad, is_runt, is_giant;

    logic        emit, emit_sop, emit_eop;
    logic [31:0] emit_data;
    logic [1:0]  emit_mod;

    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;
    logic [1:0]  out_mod_q, out_mod_d;
    logic [15:0] out_len_q, out_len_d;
    logic        out_fcs_err_q, out_fcs_err_d;
    logic        out_runt_q, out_runt_d;
    logic        out_giant_q, out_giant_d;

    logic [31:0] cnt_good_q, cnt_good_d;
    logic [31:0] cnt_fcs_err_q, cnt_fcs_err_d;
    logic [31:0] cnt_runt_q, cnt_runt_d;
    logic [31:0] cnt_giant_q, cnt_giant_d;
    logic [31:0] cnt_abort_q, cnt_abort_d;

`ifdef RX_FCS_STRIP_EN
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_sop_q, hold_sop_d;
    logic        hold_vld_q, hold_vld_d;
`endif

    assign beat_vld  = par_en & in_valid;
    assign word_take = beat_vld & (in_sop | (state_q == ST_FRAME));
    assign orphan    = beat_vld & ~in_sop & (state_q == ST_IDLE);
    assign abandon   = beat_vld & in_sop & (state_q == ST_FRAME);
    assign frame_end = word_take & in_eop;

    // A sop word always restarts CRC and length, which also covers an abandoned frame.
    assign nbytes   = (in_eop && in_mod != 2'd0) ? {1'b0, in_mod} : 3'd4;
    assign crc_base = in_sop ? CRC_INIT : crc_q;
    assign len_base = in_sop ? 16'd0 : len_q;
    assign len_sum  = {1'b0, len_base} + {14'd0, nbytes};
    assign len_new  = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    crc32_d32_be u_crc (
        .crc_in  (crc_base),
        .data_in (in_data),
        .nbytes  (nbytes),
        .crc_out (crc_next)
    );

    assign fcs_bad  = (crc_next != CRC_RESIDUE);
    assign is_runt  = (len_new < MIN_FRAME_LEN);
    assign is_giant = (len_new > MAX_LEN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            crc_q   <= 32'd0;
            len_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        if (word_take) begin
            state_d = in_eop ? ST_IDLE : ST_FRAME;
            crc_d   = crc_next;
            len_d   = len_new;
        end
    end

    always_comb begin
        emit      = 1'b0;
        emit_data = in_data;
        emit_sop  = in_sop;
        emit_eop  = in_eop;
        emit_mod  = in_mod;
`ifdef RX_FCS_STRIP_EN
        // Each word waits for its successor; the eop word itself is pure FCS tail and is dropped.
        hold_data_d = hold_data_q;
        hold_sop_d  = hold_sop_q;
        hold_vld_d  = hold_vld_q;
        if (word_take) begin
            hold_data_d = in_data;
            hold_sop_d  = in_sop;
            hold_vld_d  = ~in_eop;
            if (!in_sop && hold_vld_q) begin
                emit      = 1'b1;
                emit_data = hold_data_q;
                emit_sop  = hold_sop_q;
                emit_eop  = in_eop;
                emit_mod  = in_eop ? in_mod : 2'd0;
            end
        end
`else
        emit = word_take;
`endif

        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_mod_d     = out_mod_q;
        out_len_d     = out_len_q;
        out_fcs_err_d = out_fcs_err_q;
        out_runt_d    = out_runt_q;
        out_giant_d   = out_giant_q;
        if (par_en) begin
            out_valid_d   = emit;
            out_data_d    = emit ? emit_data : 32'd0;
            out_sop_d     = emit & emit_sop;
            out_eop_d     = emit & emit_eop;
            out_mod_d     = emit ? emit_mod : 2'd0;
            out_len_d     = (emit && emit_eop) ? len_new : 16'd0;
            out_fcs_err_d = emit & emit_eop & fcs_bad;
            out_runt_d    = emit & emit_eop & is_runt;
            out_giant_d   = emit & emit_eop & is_giant;
        end
    end

    always_comb begin
        cnt_good_d    = cnt_good_q;
        cnt_fcs_err_d = cnt_fcs_err_q;
        cnt_runt_d    = cnt_runt_q;
        cnt_giant_d   = cnt_giant_q;
        cnt_abort_d   = cnt_abort_q;
        if (frame_end) begin
            if (fcs_bad) cnt_fcs_err_d = sat_inc32(cnt_fcs_err_q);
            else         cnt_good_d    = sat_inc32(cnt_good_q);
            if (is_runt)  cnt_runt_d  = sat_inc32(cnt_runt_q);
            if (is_giant) cnt_giant_d = sat_inc32(cnt_giant_q);
        end
        if (orphan || abandon) cnt_abort_d = sat_inc32(cnt_abort_q);
        if (clr_cnt) begin
            cnt_good_d    = 32'd0;
            cnt_fcs_err_d = 32'd0;
            cnt_runt_d    = 32'd0;
            cnt_giant_d   = 32'd0;
            cnt_abort_d   = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q    <= 32'd0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_mod_q     <= 2'd0;
            out_len_q     <= 16'd0;
            out_fcs_err_q <= 1'b0;
            out_runt_q    <= 1'b0;
            out_giant_q   <= 1'b0;
            cnt_good_q    <= 32'd0;
            cnt_fcs_err_q <= 32'd0;
            cnt_runt_q    <= 32'd0;
            cnt_giant_q   <= 32'd0;
            cnt_abort_q   <= 32'd0;
        end else begin
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_mod_q     <= out_mod_d;
            out_len_q     <= out_len_d;
            out_fcs_err_q <= out_fcs_err_d;
            out_runt_q    <= out_runt_d;
            out_giant_q   <= out_giant_d;
            cnt_good_q    <= cnt_good_d;
            cnt_fcs_err_q <= cnt_fcs_err_d;
            cnt_runt_q    <= cnt_runt_d;
            cnt_giant_q   <= cnt_giant_d;
            cnt_abort_q   <= cnt_abort_d;
        end
    end

`ifdef RX_FCS_STRIP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_data_q <= 32'd0;
            hold_sop_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_sop_q  <= hold_sop_d;
            hold_vld_q  <= hold_vld_d;
        end
    end
`endif

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_mod     = out_mod_q;
    assign out_len     = out_len_q;
    assign out_fcs_err = out_fcs_err_q;
    assign out_runt    = out_runt_q;
    assign out_giant   = out_giant_q;
    assign cnt_good    = cnt_good_q;
    assign cnt_fcs_err = cnt_fcs_err_q;
    assign cnt_runt    = cnt_runt_q;
    assign cnt_giant   = cnt_giant_q;
    assign cnt_abort   = cnt_abort_q;

endmodule
